// File: rtl/mem_bank_arb.sv
// mem_bank_arb: two-client round-robin arbiter for one memory bank port.
// Commands carry the client index in tag bit 0; read returns route by qtag.
module mem_bank_arb #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 32,
    parameter int TAG_WIDTH     = 2,
    parameter int BE_WIDTH      = 16,
    parameter int MAX_BURST     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 c_req,
    input  logic [1:0]                 c_ce,
    input  logic [1:0]                 c_w,
    input  logic [2*ADDRESS_WIDTH-1:0] c_a,
    input  logic [2*DATA_WIDTH-1:0]    c_d,
    input  logic [2*BE_WIDTH-1:0]      c_be,
    output logic [1:0]                 c_gnt,
    output logic [1:0]                 c_ready,
    output logic [1:0]                 c_valid,
    output logic [DATA_WIDTH-1:0]      c_q,
    output logic                       req,
    output logic                       ce,
    output logic                       w,
    output logic [ADDRESS_WIDTH-1:0]   a,
    output logic [TAG_WIDTH-1:0]       tag,
    output logic [DATA_WIDTH-1:0]      d,
    output logic [BE_WIDTH-1:0]        be,
    input  logic                       ready,
    input  logic                       valid,
    input  logic [DATA_WIDTH-1:0]      q,
    input  logic [TAG_WIDTH-1:0]       qtag,
    output logic                       busy,
    output logic [2*8-1:0]             rd_pend
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] MB = 8'(MAX_BURST);

    state_t          state;
    state_t          state_nx;
    logic            last;
    logic [7:0]      burst_cnt;
    logic            accept;
    logic            burst_hit;
    logic [1:0]      rd_inc;
    logic [1:0][7:0] pend;
    logic            unused_qtag;

    assign c_gnt   = {state == OWN1, state == OWN0};
    assign busy    = (state != IDLE);
    assign req     = |c_req;
    assign ce      = |(c_gnt & c_ce);
    assign tag     = TAG_WIDTH'(c_gnt[1]);
    assign c_ready = c_gnt & {2{ready}};
    assign accept  = ce & ready;

    assign c_valid = {valid & qtag[0], valid & ~qtag[0]};
    assign c_q     = q;

    assign rd_inc  = c_gnt & c_ce & ~c_w & {2{ready}};
    assign rd_pend = pend;

    assign unused_qtag = ^{1'b0, qtag};

    // The switch decision lands in the cycle of the MAX_BURST-th accept.
    assign burst_hit = (burst_cnt >= MB) ||
                       (accept && (burst_cnt == MB - 8'd1));

    // Route the owner's command fields onto the bank; zero while idle.
    always_comb begin
        w  = 1'b0;
        a  = '0;
        d  = '0;
        be = '0;
        unique case (1'b1)
            c_gnt[0]: begin
                w  = c_w[0];
                a  = c_a[0 +: ADDRESS_WIDTH];
                d  = c_d[0 +: DATA_WIDTH];
                be = c_be[0 +: BE_WIDTH];
            end
            c_gnt[1]: begin
                w  = c_w[1];
                a  = c_a[ADDRESS_WIDTH +: ADDRESS_WIDTH];
                d  = c_d[DATA_WIDTH +: DATA_WIDTH];
                be = c_be[BE_WIDTH +: BE_WIDTH];
            end
            default: ;
        endcase
    end

    // Ownership decision: round-robin from idle, hand-over on drop or burst limit.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (c_req == 2'b11)
                    state_nx = last ? OWN0 : OWN1;
                else if (c_req[0])
                    state_nx = OWN0;
                else if (c_req[1])
                    state_nx = OWN1;
            end
            OWN0: begin
                if (!c_req[0])
                    state_nx = c_req[1] ? OWN1 : IDLE;
                else if (burst_hit && c_req[1])
                    state_nx = OWN1;
            end
            OWN1: begin
                if (!c_req[1])
                    state_nx = c_req[0] ? OWN0 : IDLE;
                else if (burst_hit && c_req[0])
                    state_nx = OWN0;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State, last owner and per-grant accept counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            last      <= 1'b1;
            burst_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) begin
                burst_cnt <= '0;
                if (state != IDLE)
                    last <= c_gnt[1];
            end else if (accept && burst_cnt < MB) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    // Saturating outstanding-read counters per client.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (rd_inc[i] && !c_valid[i] && pend[i] != 8'hff)
                    pend[i] <= pend[i] + 8'd1;
                else if (c_valid[i] && !rd_inc[i] && pend[i] != 8'h00)
                    pend[i] <= pend[i] - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_bank_arb.sv
// tb_mem_bank_arb: directed scenarios plus randomized traffic
// compared against a cycle-level ownership model of the arbiter.
module tb_mem_bank_arb;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int TW   = 2;
    localparam int BW   = 4;
    localparam int MAXB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        c_req, c_ce, c_w;
    logic [2*AW-1:0]   c_a;
    logic [2*DW-1:0]   c_d;
    logic [2*BW-1:0]   c_be;
    logic [1:0]        c_gnt, c_ready, c_valid;
    logic [DW-1:0]     c_q;
    logic              req, ce, w;
    logic [AW-1:0]     a;
    logic [TW-1:0]     tag;
    logic [DW-1:0]     d;
    logic [BW-1:0]     be;
    logic              ready, valid;
    logic [DW-1:0]     q;
    logic [TW-1:0]     qtag;
    logic              busy;
    logic [15:0]       rd_pend;

    int errors = 0;
    int checks = 0;

    // Reference model state: owner (-1 idle), last owner,
    // accepts in current grant, outstanding reads per client.
    int m_own  = -1;
    int m_last = 1;
    int m_cnt  = 0;
    int m_pend [2] = '{0, 0};

    always #5 clk = ~clk;

    mem_bank_arb #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .TAG_WIDTH    (TW),
        .BE_WIDTH     (BW),
        .MAX_BURST    (MAXB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .c_req  (c_req),
        .c_ce   (c_ce),
        .c_w    (c_w),
        .c_a    (c_a),
        .c_d    (c_d),
        .c_be   (c_be),
        .c_gnt  (c_gnt),
        .c_ready(c_ready),
        .c_valid(c_valid),
        .c_q    (c_q),
        .req    (req),
        .ce     (ce),
        .w      (w),
        .a      (a),
        .tag    (tag),
        .d      (d),
        .be     (be),
        .ready  (ready),
        .valid  (valid),
        .q      (q),
        .qtag   (qtag),
        .busy   (busy),
        .rd_pend(rd_pend)
    );

    task automatic model_step();
        int  nown;
        int  ncnt;
        int  o;
        bit  acc;
        bit  inc;
        bit  dec;
        acc = (m_own >= 0) && c_ce[m_own] && ready;
        if (!rst) begin
            m_own  = -1;
            m_last = 1;
            m_cnt  = 0;
            m_pend = '{0, 0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                inc = acc && (m_own == i) && !c_w[i];
                dec = valid && (int'(qtag[0]) == i);
                if (inc && !dec && m_pend[i] < 255)
                    m_pend[i]++;
                else if (dec && !inc && m_pend[i] > 0)
                    m_pend[i]--;
            end
            if (m_own < 0) begin
                if (c_req == 2'b11)
                    nown = 1 - m_last;
                else if (c_req[0])
                    nown = 0;
                else if (c_req[1])
                    nown = 1;
                else
                    nown = -1;
                ncnt = 0;
            end else begin
                o    = 1 - m_own;
                ncnt = m_cnt + int'(acc);
                if (!c_req[m_own])
                    nown = c_req[o] ? o : -1;
                else if (ncnt >= MAXB && c_req[o])
                    nown = o;
                else
                    nown = m_own;
            end
            if (nown != m_own) begin
                if (m_own >= 0)
                    m_last = m_own;
                m_cnt = 0;
            end else begin
                m_cnt = (ncnt > MAXB) ? MAXB : ncnt;
            end
            m_own = nown;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        c_req = 2'b11;
        c_ce  = 2'b11;
        c_w   = 2'b11;
        c_a   = {$urandom, $urandom};
        c_d   = {$urandom, $urandom};
        c_be  = 8'hff;
        ready = 1'b1;
        valid = 1'b0;
        qtag  = '0;
        q     = '0;
        next();
        next();
        next();
        @(negedge clk);
        checks++;
        if ({c_gnt, busy, c_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_gnt got=%b exp=00000", {c_gnt, busy, c_ready});
        end
        checks++;
        if ({ce, w, a, d, be, tag} !== '0) begin
            errors++;
            $display("FAIL reset_bank got=%h exp=0", {ce, w, a, d, be, tag});
        end
        checks++;
        if (rd_pend !== 16'h0) begin
            errors++;
            $display("FAIL reset_pend got=%h exp=0", rd_pend);
        end
        next();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (c_gnt !== 2'b00) begin
            errors++;
            $display("FAIL release_same_cycle got=%b exp=00", c_gnt);
        end
        next();
        @(negedge clk);
        checks++;
        if (c_gnt !== 2'b01) begin
            errors++;
            $display("FAIL release_gnt got=%b exp=01", c_gnt);
        end
        next();
        c_req = 2'b00;
        c_ce  = 2'b00;
        next();
        next();
    endtask

    task automatic test_single();
        int       pulses;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [BW-1:0] eb;
        pulses = 0;
        c_req  = 2'b10;
        c_ce   = 2'b00;
        @(negedge clk);
        checks++;
        if (c_gnt !== 2'b00) begin
            errors++;
            $display("FAIL single_req_cycle got=%b exp=00", c_gnt);
        end
        next();
        for (int k = 0; k < 5; k++) begin
            ea   = AW'(16'h0100 + k);
            ed   = $urandom;
            eb   = BW'($urandom);
            c_ce = 2'b10;
            c_w  = 2'b10;
            c_a  = {ea, 16'hdead};
            c_d  = {ed, 32'hbeef_0000};
            c_be = {eb, 4'h5};
            ready = 1'b1;
            @(negedge clk);
            pulses += int'(ce);
            checks++;
            if ({c_gnt, c_ready, ce, w, tag, a, d, be} !==
                {2'b10, 2'b10, 1'b1, 1'b1, 2'd1, ea, ed, eb}) begin
                errors++;
                $display("FAIL single_write%0d got=%h exp=%h", k,
                         {c_gnt, c_ready, ce, w, tag, a, d, be},
                         {2'b10, 2'b10, 1'b1, 1'b1, 2'd1, ea, ed, eb});
            end
            next();
        end
        checks++;
        if (pulses != 5) begin
            errors++;
            $display("FAIL single_pulses got=%0d exp=5", pulses);
        end
        c_ce  = 2'b00;
        c_req = 2'b00;
        next();
        @(negedge clk);
        checks++;
        if ({c_gnt, ce, busy} !== 4'b0) begin
            errors++;
            $display("FAIL single_release got=%b exp=0000", {c_gnt, ce, busy});
        end
        next();
    endtask

    task automatic test_fairness();
        int got;
        int exp;
        c_req = 2'b11;
        c_ce  = 2'b11;
        c_w   = 2'b11;
        ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            got = (ce && ready) ? int'(tag[0]) : -1;
            exp = (k == 0) ? -1 : ((k - 1) / 4) % 2;
            checks++;
            if (got != exp) begin
                errors++;
                $display("FAIL fair_cycle%0d got=%0d exp=%0d", k, got, exp);
            end
            next();
        end
        c_req = 2'b00;
        c_ce  = 2'b00;
        next();
        next();
    endtask

    task automatic test_backpressure();
        int seq [$];
        int exp;
        c_req = 2'b11;
        c_ce  = 2'b11;
        c_w   = 2'b11;
        for (int k = 0; k < 40; k++) begin
            ready = (k % 2 == 0);
            @(negedge clk);
            if (ce && ready)
                seq.push_back(int'(tag[0]));
            next();
        end
        checks++;
        if (seq.size() != 19) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=19", seq.size());
        end
        for (int j = 0; j < 16 && j < seq.size(); j++) begin
            exp = ((j / 4) % 2 == 0) ? 1 : 0;
            checks++;
            if (seq[j] != exp) begin
                errors++;
                $display("FAIL bp_accept%0d got=%0d exp=%0d", j, seq[j], exp);
            end
        end
        c_req = 2'b00;
        c_ce  = 2'b00;
        ready = 1'b1;
        next();
        next();
    endtask

    task automatic test_read_routing();
        int            tags [5] = '{1, 0, 1, 0, 0};
        logic [DW-1:0] qv;
        c_req = 2'b01;
        c_ce  = 2'b00;
        c_w   = 2'b00;
        ready = 1'b1;
        next();
        for (int k = 0; k < 3; k++) begin
            c_ce = 2'b01;
            c_a  = {$urandom, $urandom};
            @(negedge clk);
            checks++;
            if ({c_ready, ce} !== 3'b011) begin
                errors++;
                $display("FAIL rd0_accept%0d got=%b exp=011", k, {c_ready, ce});
            end
            next();
        end
        c_req = 2'b10;
        c_ce  = 2'b00;
        next();
        for (int k = 0; k < 2; k++) begin
            c_ce = 2'b10;
            @(negedge clk);
            checks++;
            if ({c_ready, ce, tag} !== 5'b10101) begin
                errors++;
                $display("FAIL rd1_accept%0d got=%b exp=10101", k, {c_ready, ce, tag});
            end
            next();
        end
        c_ce  = 2'b00;
        c_req = 2'b00;
        @(negedge clk);
        checks++;
        if (rd_pend !== {8'd2, 8'd3}) begin
            errors++;
            $display("FAIL rd_pend_issued got=%h exp=0203", rd_pend);
        end
        next();
        for (int j = 0; j < 5; j++) begin
            qv    = $urandom;
            valid = 1'b1;
            qtag  = {1'($urandom), 1'(tags[j])};
            q     = qv;
            @(negedge clk);
            checks++;
            if ({c_valid, c_q} !== {(tags[j] == 1) ? 2'b10 : 2'b01, qv}) begin
                errors++;
                $display("FAIL rd_return%0d got=%b/%h exp=%0d/%h", j,
                         c_valid, c_q, tags[j], qv);
            end
            next();
        end
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_pend !== 16'h0) begin
            errors++;
            $display("FAIL rd_pend_drained got=%h exp=0000", rd_pend);
        end
        next();
    endtask

    task automatic test_mid_reset();
        c_req = 2'b01;
        c_ce  = 2'b00;
        c_w   = 2'b00;
        ready = 1'b1;
        next();
        c_ce = 2'b01;
        next();
        next();
        c_ce = 2'b00;
        @(negedge clk);
        checks++;
        if ({c_gnt, rd_pend} !== {2'b01, 16'h0002}) begin
            errors++;
            $display("FAIL mid_pre got=%h exp=10002", {c_gnt, rd_pend});
        end
        next();
        rst = 1'b0;
        next();
        rst   = 1'b1;
        c_req = 2'b00;
        valid = 1'b1;
        qtag  = '0;
        q     = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if ({c_gnt, busy, rd_pend, c_valid} !== {3'b000, 16'h0, 2'b01}) begin
            errors++;
            $display("FAIL mid_reset got=%h exp=1", {c_gnt, busy, rd_pend, c_valid});
        end
        next();
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_pend !== 16'h0) begin
            errors++;
            $display("FAIL mid_late_ret got=%h exp=0000", rd_pend);
        end
        next();
    endtask

    task automatic test_saturation();
        c_req = 2'b01;
        c_ce  = 2'b00;
        c_w   = 2'b00;
        ready = 1'b1;
        next();
        c_ce = 2'b01;
        repeat (260) next();
        c_ce = 2'b00;
        @(negedge clk);
        checks++;
        if (rd_pend[7:0] !== 8'd255) begin
            errors++;
            $display("FAIL sat_hold got=%0d exp=255", rd_pend[7:0]);
        end
        next();
        valid = 1'b1;
        qtag  = '0;
        next();
        valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_pend[7:0] !== 8'd254) begin
            errors++;
            $display("FAIL sat_dec got=%0d exp=254", rd_pend[7:0]);
        end
        c_req = 2'b00;
        next();
        next();
    endtask

    task automatic test_random();
        logic [1:0]    eg;
        logic          ece, ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [BW-1:0] eb;
        logic [TW-1:0] et;
        logic [1:0]    ev;
        for (int n = 0; n < 600; n++) begin
            rst   = ($urandom % 64) != 0;
            c_req = 2'($urandom | $urandom);
            c_ce  = 2'($urandom);
            c_w   = 2'($urandom);
            c_a   = {$urandom, $urandom};
            c_d   = {$urandom, $urandom};
            c_be  = 8'($urandom);
            ready = 1'($urandom);
            valid = 1'($urandom);
            qtag  = 2'($urandom);
            q     = $urandom;
            @(negedge clk);
            eg  = (m_own < 0) ? 2'b00 : ((m_own == 0) ? 2'b01 : 2'b10);
            ece = 1'b0;
            ew  = 1'b0;
            ea  = '0;
            ed  = '0;
            eb  = '0;
            if (m_own >= 0) begin
                ece = c_ce[m_own];
                ew  = c_w[m_own];
                ea  = c_a[m_own*AW +: AW];
                ed  = c_d[m_own*DW +: DW];
                eb  = c_be[m_own*BW +: BW];
            end
            et = (m_own == 1) ? 2'd1 : 2'd0;
            ev = valid ? (qtag[0] ? 2'b10 : 2'b01) : 2'b00;
            checks++;
            if ({c_gnt, busy} !== {eg, m_own >= 0}) begin
                errors++;
                $display("FAIL rnd_gnt%0d got=%b exp=%b", n, {c_gnt, busy}, {eg, m_own >= 0});
            end
            checks++;
            if ({req, ce, w, a, d, be, tag} !== {|c_req, ece, ew, ea, ed, eb, et}) begin
                errors++;
                $display("FAIL rnd_bank%0d got=%h exp=%h", n,
                         {req, ce, w, a, d, be, tag}, {|c_req, ece, ew, ea, ed, eb, et});
            end
            checks++;
            if (c_ready !== (ready ? eg : 2'b00)) begin
                errors++;
                $display("FAIL rnd_ready%0d got=%b exp=%b", n, c_ready, ready ? eg : 2'b00);
            end
            checks++;
            if ({c_valid, c_q} !== {ev, q}) begin
                errors++;
                $display("FAIL rnd_ret%0d got=%h exp=%h", n, {c_valid, c_q}, {ev, q});
            end
            checks++;
            if (rd_pend !== {8'(m_pend[1]), 8'(m_pend[0])}) begin
                errors++;
                $display("FAIL rnd_pend%0d got=%h exp=%h", n, rd_pend,
                         {8'(m_pend[1]), 8'(m_pend[0])});
            end
            next();
        end
        rst = 1'b1;
    endtask

    initial begin
        rst   = 1'b0;
        c_req = '0;
        c_ce  = '0;
        c_w   = '0;
        c_a   = '0;
        c_d   = '0;
        c_be  = '0;
        ready = 1'b0;
        valid = 1'b0;
        q     = '0;
        qtag  = '0;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_read_routing();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bank_arb.md
# mem_bank_arb

Two-client round-robin arbiter that shares one memory bank port (req/ce/w/a/tag/d/be out, ready/valid/q/qtag in) between two streaming memory agents. Each client keeps a bank-style interface with its own grant. The arbiter tags every command with the client index and routes read returns by `qtag`, so one bank can serve a read stream and a write stream, or two PEs. It sits between the `sma` instances and a bank slice of the top-level memory bus.

## Interface
- `DATA_WIDTH`, 128, data bus width
- `ADDRESS_WIDTH`, 32, address width
- `TAG_WIDTH`, 2, bank tag width (≥1); tag bit 0 carries the client index
- `BE_WIDTH`, 16, byte enables (DATA_WIDTH/8)
- `MAX_BURST`, 16, accepted commands per grant before forced hand-over when the other client waits (≥1, ≤255)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-low reset
- `c_req`  in  2  client i wants the bank (bit i)
- `c_ce`  in  2  client i command strobe
- `c_w`  in  2  client i write (1) / read (0)
- `c_a`  in  2*ADDRESS_WIDTH  client addresses, packed `[i*AW +: AW]`
- `c_d`  in  2*DATA_WIDTH  client write data
- `c_be`  in  2*BE_WIDTH  client byte enables
- `c_gnt`  out  2  client i owns the bank
- `c_ready`  out  2  client i command accepted this cycle when `c_ce[i]` is high
- `c_valid`  out  2  read data valid for client i
- `c_q`  out  DATA_WIDTH  read data, shared by both clients, qualified by `c_valid`
- `req`, `ce`, `w`  out  1  to bank
- `a`  out  ADDRESS_WIDTH  to bank
- `tag`  out  TAG_WIDTH  to bank
- `d`  out  DATA_WIDTH  to bank
- `be`  out  BE_WIDTH  to bank
- `ready`, `valid`  in  1  from bank
- `q`  in  DATA_WIDTH  from bank
- `qtag`  in  TAG_WIDTH  from bank
- `busy`  out  1  state ≠ IDLE
- `rd_pend`  out  2*8  outstanding reads per client, saturating at 255

## Operation
- States: IDLE, OWN0, OWN1. `c_gnt` is decoded from the registered state.
- **IDLE**
  - Only one of `c_req` set: go to that OWNi.
  - Both set: go to the client that is not `last`.
  - `last` is a 1-bit register; reset value 1, so client 0 wins first.
- **OWNi**
  - `c_req[i]`=0: go to OWN(1-i) if `c_req[1-i]`, else IDLE.
  - `burst_cnt` reaches MAX_BURST and `c_req[1-i]`=1: go to OWN(1-i).
  - Otherwise stay in OWNi.
  - On leaving OWNi, set `last`←i.
- `burst_cnt` counts `ce & ready` while in OWNi. It clears on every state change and saturates at MAX_BURST.
- Bank mux, combinational from state:
  - `req` = `|c_req`.
  - `ce` = `c_gnt[i] & c_ce[i]`.
  - `w`/`a`/`d`/`be` come from the owner; all zero in IDLE.
  - `tag` = zero-extended i.
- `c_ready[i]` = `c_gnt[i] & ready`.
- The accept event is `ce & ready`.
- Read return:
  - `c_valid[i]` = `valid & (qtag[0]==i)`.
  - `c_q` = `q`, passed through with no register.
- `rd_pend[i]`:
  - +1 on an accepted read from client i.
  - −1 on `c_valid[i]`.
  - Accept and return in the same cycle leave it unchanged.
  - A return while the count is 0 leaves it at 0.
  - An increment at 255 holds at 255.
- Hand-over does not wait for `rd_pend`. Reads stay in flight; tags keep the returns separate.

## Timing
- Request to grant: `c_req[i]` rises in cycle N (state IDLE) → `c_gnt[i]`=1 in N+1 → first possible accept in N+1.
- Hand-over:
  - The switch decision is made in cycle N, where the MAX_BURST-th accept occurs or the owner drops `c_req`.
  - The new owner is granted in N+1. No idle bubble.
  - The old owner must not assume acceptance after N; `c_ready` is low for it from N+1.
- Grant release: the owner drops `c_req` with the other client idle → IDLE in N+1, and `ce`=0 from N+1.
- Read-return latency equals the bank's latency; the arbiter adds zero cycles.
- Reset (`rst`=0 at a clock edge) forces:
  - state IDLE, `last`=1, `burst_cnt`=0, `rd_pend`=0.
  - `c_gnt`=0, `busy`=0. Combinationally `ce`=0, `tag`=0, and `a`/`d`/`be`/`w`=0.
  - Reads in flight at reset are dropped from `rd_pend`. Late `valid` pulses are still routed by `qtag`.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with both `c_req`=1 → all outputs 0 and `busy`=0. Release → `c_gnt`=01 one cycle later.
- **Single client:** client 1 requests alone and issues 5 writes with `ready`=1 → `c_gnt`=10 from N+1. The bank sees 5 `ce` pulses with `tag`=1 and client 1's addresses and data.
- **Fairness:** both clients stream continuously, MAX_BURST=4, `ready` always 1 → accepts alternate in runs of 4 (0,0,0,0,1,1,1,1,...) with no idle cycle between runs.
- **Backpressure:** as in the fairness test, but toggle `ready` 1010… → `burst_cnt` counts only accepted cycles; each run still contains 4 accepts.
- **Read routing:** client 0 issues 3 reads, then client 1 issues 2 reads. The bank returns them interleaved with `qtag` 1,0,1,0,0 → `c_valid` pulses follow that order. `rd_pend` goes 3/2 → 0/0.
- **Mid-burst reset:** assert reset during OWN0 with `rd_pend[0]`=2 → IDLE next cycle and `rd_pend`=0. A following `valid` with `qtag`=0 pulses `c_valid[0]` and `rd_pend[0]` stays 0.
